// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture block: active-low segment
// patterns, FSM state encoding and the one-cold strobe test.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Widest strobe bus is_one_cold accepts; callers pad unused bits with ones.
  localparam int MAX_DIGITS = 32;

  typedef enum logic {
    S_HELD   = 1'b0,
    S_SETTLE = 1'b1
  } state_t;

  function automatic logic is_one_cold(input logic [MAX_DIGITS-1:0] an);
    int zeros;
    zeros = 0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (!an[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low a..g segment pattern back to a digit
// value, flagging the all-off pattern and any pattern outside the table.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_val,
  output logic       o_blank,
  output logic       o_err
);

  always_comb begin
    o_val   = 4'hF;
    o_blank = 1'b0;
    o_err   = 1'b0;
    case (i_seg)
      SEG_0:     o_val = 4'd0;
      SEG_1:     o_val = 4'd1;
      SEG_2:     o_val = 4'd2;
      SEG_3:     o_val = 4'd3;
      SEG_4:     o_val = 4'd4;
      SEG_5:     o_val = 4'd5;
      SEG_6:     o_val = 4'd6;
      SEG_7:     o_val = 4'd7;
      SEG_8:     o_val = 4'd8;
      SEG_9:     o_val = 4'd9;
      SEG_BLANK: o_blank = 1'b1;
      default:   o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers digit values from a multiplexed 7-segment bus: waits for the
// strobe/segment combination to settle, decodes it and stores it per digit.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter  int N_DIGITS   = 4,
  parameter  int STABLE_CYC = 4,
  localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_DIGITS-1:0]   i_an,
  input  logic [6:0]            i_seg,
  output logic [4*N_DIGITS-1:0] o_digits,
  output logic [N_DIGITS-1:0]   o_blank,
  output logic [N_DIGITS-1:0]   o_err,
  output logic                  o_cap_valid,
  output logic [IDX_W-1:0]      o_cap_idx,
  output logic                  o_frame_valid
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(STABLE_CYC - 1);

  state_t                  state, state_next;
  logic [N_DIGITS-1:0]     held_an, held_an_next;
  logic [6:0]              held_seg, held_seg_next;
  cnt_t                    cnt, cnt_next;
  logic [N_DIGITS-1:0]     seen;
  logic                    changed;
  logic                    capture;
  logic                    frame_done;
  logic [MAX_DIGITS-1:0]   an_pad;
  logic [N_DIGITS-1:0]     cap_mask;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              dec_val;
  logic                    dec_blank;
  logic                    dec_err;

  // During a capture the input equals held, so decoding held.seg is current.
  seg7_to_bcd u_dec (
    .i_seg   (held_seg),
    .o_val   (dec_val),
    .o_blank (dec_blank),
    .o_err   (dec_err)
  );

  always_comb begin
    changed       = ({i_an, i_seg} != {held_an, held_seg});
    an_pad        = '1;
    an_pad[N_DIGITS-1:0] = held_an;
    cap_mask      = ~held_an;
    idx           = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (!held_an[k]) idx = IDX_W'(k);
    end

    state_next    = state;
    held_an_next  = held_an;
    held_seg_next = held_seg;
    cnt_next      = cnt;
    capture       = 1'b0;

    // Any change restarts the settle window, even on what would be the capture edge.
    if (changed) begin
      held_an_next  = i_an;
      held_seg_next = i_seg;
      cnt_next      = '0;
      state_next    = S_SETTLE;
    end else if (state == S_SETTLE) begin
      if (cnt == CNT_LAST) begin
        state_next = S_HELD;
        capture    = is_one_cold(an_pad);
      end else begin
        cnt_next = cnt + cnt_t'(1);
      end
    end

    frame_done = &(seen | cap_mask);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_HELD;
      held_an       <= '1;
      held_seg      <= '1;
      cnt           <= '0;
      seen          <= '0;
      o_digits      <= '0;
      o_blank       <= '0;
      o_err         <= '0;
      o_cap_valid   <= 1'b0;
      o_cap_idx     <= '0;
      o_frame_valid <= 1'b0;
    end else begin
      state         <= state_next;
      held_an       <= held_an_next;
      held_seg      <= held_seg_next;
      cnt           <= cnt_next;
      o_cap_valid   <= capture;
      o_frame_valid <= capture && frame_done;
      if (capture) begin
        o_cap_idx <= idx;
        seen      <= frame_done ? '0 : (seen | cap_mask);
        for (int k = 0; k < N_DIGITS; k++) begin
          if (cap_mask[k]) begin
            o_digits[4*k +: 4] <= dec_val;
            o_blank[k]         <= dec_blank;
            o_err[k]           <= dec_err;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture (N_DIGITS=4, STABLE_CYC=4) with a
// window-based reference model and a capture scoreboard.
module tb_seg7_scan_capture;

  localparam int N = 4;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an  = '1;
  logic [6:0]  seg = '1;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        cap_valid;
  logic [1:0]  cap_idx;
  logic        frame_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_capture #(.N_DIGITS(N), .STABLE_CYC(S)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_an          (an),
    .i_seg         (seg),
    .o_digits      (digits),
    .o_blank       (blank),
    .o_err         (err),
    .o_cap_valid   (cap_valid),
    .o_cap_idx     (cap_idx),
    .o_frame_valid (frame_valid)
  );

  // ---------------- reference model ----------------
  logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // A capture happens on the edge that completes S+1 equal samples whose
  // predecessor differed; samples before reset count as all-ones.
  logic [10:0] hist [$];
  logic        m_cap, m_frame;
  logic [1:0]  m_idx;
  logic [15:0] m_digits;
  logic [3:0]  m_blank, m_err;
  bit          m_seen [N];
  logic [5:0]  exp_q [$];

  function automatic logic [5:0] ref_decode(input logic [6:0] s);
    logic [5:0] r;
    r = {2'b01, 4'hF};
    if (s == 7'h7F) r = {2'b10, 4'hF};
    for (int v = 0; v < 10; v++) begin
      if (s == seg_tbl[v]) r = {2'b00, 4'(v)};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    logic [10:0] cur;
    logic [5:0]  d;
    bit          fire, all_seen;
    int          k;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < S + 1; i++) hist.push_back('1);
      exp_q.delete();
      m_cap = 0; m_frame = 0; m_idx = 0;
      m_digits = 0; m_blank = 0; m_err = 0;
      for (int i = 0; i < N; i++) m_seen[i] = 0;
    end else begin
      cur = {an, seg};
      hist.push_back(cur);
      if (hist.size() > S + 2) void'(hist.pop_front());
      m_cap = 0; m_frame = 0;
      fire = (hist.size() == S + 2) && (hist[0] != cur);
      for (int i = 1; i <= S; i++) if (hist.size() == S + 2 && hist[i] != cur) fire = 0;
      if (fire && $countones(~an) == 1) begin
        k = 0;
        for (int i = 0; i < N; i++) if (!an[i]) k = i;
        d = ref_decode(seg);
        m_cap = 1;
        m_idx = 2'(k);
        m_digits[4*k +: 4] = d[3:0];
        m_blank[k] = d[5];
        m_err[k] = d[4];
        exp_q.push_back({2'(k), d[3:0]});
        m_seen[k] = 1;
        all_seen = 1;
        for (int i = 0; i < N; i++) if (!m_seen[i]) all_seen = 0;
        if (all_seen) begin
          m_frame = 1;
          for (int i = 0; i < N; i++) m_seen[i] = 0;
        end
      end
    end
  end

  // ---------------- driver and observation tallies ----------------
  int obs_caps, obs_frames, exp_caps, frame_at, diff_cycles, sb_bad;

  task automatic clear_stats();
    obs_caps = 0; obs_frames = 0; exp_caps = 0; frame_at = -1; diff_cycles = 0; sb_bad = 0;
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    logic [5:0] front;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      an = a; seg = s;
      @(posedge clk);
      #1;
      if (m_cap) exp_caps++;
      if (cap_valid === 1'b1) begin
        obs_caps++;
        if (exp_q.size() == 0) sb_bad++;
        else begin
          front = exp_q.pop_front();
          if (front !== {cap_idx, digits[4*cap_idx +: 4]}) sb_bad++;
        end
      end
      if (frame_valid === 1'b1) begin
        obs_frames++;
        frame_at = obs_caps;
      end
      if (cap_valid !== m_cap || frame_valid !== m_frame || digits !== m_digits ||
          blank !== m_blank || err !== m_err || (m_cap && cap_idx !== m_idx))
        diff_cycles++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; an = '1; seg = '1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1; an = 4'($urandom); seg = 7'($urandom);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (digits !== 16'h0) begin errors++; $display("FAIL reset_digits: got %h want 0000", digits); end
    checks++; if (blank !== 4'h0) begin errors++; $display("FAIL reset_blank: got %b want 0000", blank); end
    checks++; if (err !== 4'h0) begin errors++; $display("FAIL reset_err: got %b want 0000", err); end
    checks++; if (cap_valid !== 1'b0 || frame_valid !== 1'b0 || cap_idx !== 2'd0) begin
      errors++; $display("FAIL reset_pulses: got cap=%b frame=%b idx=%0d want 0 0 0", cap_valid, frame_valid, cap_idx);
    end
    @(negedge clk);
    rst = 0; an = '1; seg = '1;
    clear_stats();
    hold(4'hF, 7'h7F, 12);
    checks++; if (obs_caps !== 0) begin errors++; $display("FAIL reset_idle_ones: got %0d caps want 0", obs_caps); end
  endtask

  task automatic test_single();
    do_reset();
    clear_stats();
    hold(4'b1110, 7'b0010010, 4);
    checks++; if (obs_caps !== 0) begin errors++; $display("FAIL single_early: got %0d caps want 0", obs_caps); end
    hold(4'b1110, 7'b0010010, 1);
    checks++; if (cap_valid !== 1'b1) begin errors++; $display("FAIL single_cap_valid: got %b want 1", cap_valid); end
    checks++; if (cap_idx !== 2'd0) begin errors++; $display("FAIL single_idx: got %0d want 0", cap_idx); end
    checks++; if (digits[3:0] !== 4'd2 || err[0] !== 1'b0) begin
      errors++; $display("FAIL single_value: got val=%h err=%b want 2 0", digits[3:0], err[0]);
    end
    hold(4'b1110, 7'b0010010, 3);
    checks++; if (obs_caps !== 1 || diff_cycles !== 0) begin
      errors++; $display("FAIL single_once: got caps=%0d diffs=%0d want 1 0", obs_caps, diff_cycles);
    end
  endtask

  task automatic test_scan();
    int vals [4] = '{1, 2, 3, 9};
    do_reset();
    clear_stats();
    for (int d = 0; d < 4; d++) begin
      hold(~(4'b1 << d), seg_tbl[vals[d]], 6);
      hold(4'hF, 7'h7F, 3);
    end
    checks++; if (obs_caps !== 4) begin errors++; $display("FAIL scan_caps: got %0d want 4", obs_caps); end
    checks++; if (obs_frames !== 1 || frame_at !== 4) begin
      errors++; $display("FAIL scan_frame: got frames=%0d at cap %0d want 1 at 4", obs_frames, frame_at);
    end
    checks++; if (digits !== 16'h9321) begin errors++; $display("FAIL scan_digits: got %h want 9321", digits); end
    hold(4'b1110, seg_tbl[5], 6);
    checks++; if (obs_frames !== 1 || digits !== 16'h9325) begin
      errors++; $display("FAIL scan_seen_cleared: got frames=%0d digits=%h want 1 9325", obs_frames, digits);
    end
    checks++; if (diff_cycles !== 0 || sb_bad !== 0) begin
      errors++; $display("FAIL scan_model: got diffs=%0d sb=%0d want 0 0", diff_cycles, sb_bad);
    end
  endtask

  task automatic test_glitch();
    clear_stats();
    hold(4'b1101, seg_tbl[5], 2);
    hold(4'b1101, seg_tbl[6], 1);
    hold(4'b1101, seg_tbl[5], S);
    checks++; if (obs_caps !== 0) begin errors++; $display("FAIL glitch_early: got %0d caps want 0", obs_caps); end
    hold(4'b1101, seg_tbl[5], 1);
    checks++; if (cap_valid !== 1'b1 || cap_idx !== 2'd1 || digits[7:4] !== 4'd5) begin
      errors++; $display("FAIL glitch_late_cap: got cap=%b idx=%0d val=%h want 1 1 5", cap_valid, cap_idx, digits[7:4]);
    end
    // change exactly on the would-be capture edge
    hold(4'b1011, seg_tbl[3], S);
    hold(4'b1011, seg_tbl[4], 1);
    checks++; if (obs_caps !== 1) begin errors++; $display("FAIL glitch_on_edge: got %0d caps want 1", obs_caps); end
    hold(4'hF, 7'h7F, 2);
    checks++; if (diff_cycles !== 0 || sb_bad !== 0) begin
      errors++; $display("FAIL glitch_model: got diffs=%0d sb=%0d want 0 0", diff_cycles, sb_bad);
    end
  endtask

  task automatic test_invalid();
    clear_stats();
    hold(4'b1100, seg_tbl[4], 10);
    checks++; if (obs_caps !== 0) begin errors++; $display("FAIL two_lows: got %0d caps want 0", obs_caps); end
    hold(4'b1011, 7'h7F, 5);
    checks++; if (blank[2] !== 1'b1 || err[2] !== 1'b0 || digits[11:8] !== 4'hF) begin
      errors++; $display("FAIL blank_digit: got blank=%b err=%b val=%h want 1 0 f", blank[2], err[2], digits[11:8]);
    end
  endtask

  task automatic test_err();
    clear_stats();
    hold(4'b1101, 7'b1010101, 5);
    checks++; if (err[1] !== 1'b1 || blank[1] !== 1'b0 || digits[7:4] !== 4'hF) begin
      errors++; $display("FAIL err_digit: got err=%b blank=%b val=%h want 1 0 f", err[1], blank[1], digits[7:4]);
    end
    hold(4'hF, 7'h7F, 2);
    hold(4'b1101, seg_tbl[7], 5);
    checks++; if (err[1] !== 1'b0 || digits[7:4] !== 4'd7) begin
      errors++; $display("FAIL err_recover: got err=%b val=%h want 0 7", err[1], digits[7:4]);
    end
    checks++; if (diff_cycles !== 0 || sb_bad !== 0) begin
      errors++; $display("FAIL err_model: got diffs=%0d sb=%0d want 0 0", diff_cycles, sb_bad);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_stats();
    for (int d = 0; d < 3; d++) begin
      hold(~(4'b1 << d), seg_tbl[d + 4], 5);
      hold(4'hF, 7'h7F, 2);
    end
    hold(4'b0111, seg_tbl[8], 2);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    checks++; if (digits !== 16'h0 || blank !== 4'h0 || err !== 4'h0) begin
      errors++; $display("FAIL midreset_regs: got digits=%h blank=%b err=%b want 0", digits, blank, err);
    end
    checks++; if (cap_valid !== 1'b0 || frame_valid !== 1'b0 || cap_idx !== 2'd0) begin
      errors++; $display("FAIL midreset_pulses: got cap=%b frame=%b idx=%0d want 0 0 0", cap_valid, frame_valid, cap_idx);
    end
    @(negedge clk);
    rst = 0;
    clear_stats();
    hold(4'b0111, seg_tbl[8], 5);
    checks++; if (obs_caps !== 1 || obs_frames !== 0) begin
      errors++; $display("FAIL midreset_no_frame: got caps=%0d frames=%0d want 1 0", obs_caps, obs_frames);
    end
    for (int d = 0; d < 3; d++) begin
      hold(4'hF, 7'h7F, 2);
      hold(~(4'b1 << d), seg_tbl[d], 5);
    end
    checks++; if (obs_frames !== 1 || frame_at !== 4 || digits !== 16'h8210) begin
      errors++; $display("FAIL midreset_frame: got frames=%0d at %0d digits=%h want 1 at 4 8210", obs_frames, frame_at, digits);
    end
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [6:0] s;
    do_reset();
    clear_stats();
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = ~(4'b1 << $urandom_range(0, 3));
        2:       a = 4'hF;
        default: a = 4'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       s = 7'h7F;
        1:       s = 7'($urandom);
        default: s = seg_tbl[$urandom_range(0, 9)];
      endcase
      hold(a, s, $urandom_range(1, S + 3));
    end
    hold(4'hF, 7'h7F, S + 2);
    checks++; if (diff_cycles !== 0) begin errors++; $display("FAIL random_outputs: got %0d differing cycles want 0", diff_cycles); end
    checks++; if (sb_bad !== 0 || exp_q.size() !== 0) begin
      errors++; $display("FAIL random_scoreboard: got bad=%0d left=%0d want 0 0", sb_bad, exp_q.size());
    end
    checks++; if (obs_caps !== exp_caps || obs_caps == 0) begin
      errors++; $display("FAIL random_cap_count: got %0d want %0d (nonzero)", obs_caps, exp_caps);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_scan();
    test_glitch();
    test_invalid();
    test_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
